// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - pipeline stage register with valid/ready handshake and 2-entry skid buffer
// Optional stall cycle counter is built only when PIPE_STALL_CNT_EN is defined.
module pipe_skid_reg #(
  parameter int          WIDTH      = 32,
  parameter logic [31:0] BUBBLE_VAL = 32'h00000013,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_count
`endif
);

  localparam logic [WIDTH-1:0] BUBBLE_W = WIDTH'(BUBBLE_VAL);

  // State encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_TWO   = 2'b11;

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q,  main_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic             accept;
  logic             emit;

  // Ready depends only on the skid flop, never on out_ready.
  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

  assign accept = in_valid & ~skid_valid_q;
  assign emit   = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_data_d  = BUBBLE_W;
      skid_data_d  = BUBBLE_W;
    end else begin
      case ({main_valid_q, skid_valid_q})
        ST_EMPTY: begin
          if (accept) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            main_data_d = in_data;
          end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
          end else if (emit) begin
            main_valid_d = 1'b0;
          end
        end
        ST_TWO: begin
          if (emit) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= BUBBLE_W;
      skid_data_q  <= BUBBLE_W;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_count_q;

  // Saturating; only rst clears it so stalls survive flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
    end else if (main_valid_q && !out_ready && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_q <= stall_count_q + CNT_W'(1);
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule
